// File: rtl/hazard_unit_if.sv
// hazard_unit_if: bundles the hazard controller's pipeline-facing signals.
//   master : pipeline side; drives stage indices/controls and receives stalls, flushes,
//            forwarding selects and the performance counters.
//   slave  : hazard_unit side.
interface hazard_unit_if #(
    parameter int M  = 4,
    parameter int CW = 16
);
    // decode-stage sources
    logic [M-1:0]  srcA_D;
    logic [M-1:0]  srcB_D;
    logic          useA_D;
    logic          useB_D;
    // execute stage
    logic [M-1:0]  srcA_E;
    logic [M-1:0]  srcB_E;
    logic [M-1:0]  regScr_E;
    logic          regmem_E;
    logic          branch_E;
    logic          taken_E;
    logic          pcload_E;
    // memory / writeback destinations
    logic [M-1:0]  regScr_M;
    logic          regw_M;
    logic [M-1:0]  regScr_W;
    logic          regw_W;
    // controls back to the pipeline
    logic          stall_F;
    logic          stall_D;
    logic          flush_D;
    logic          flush_E;
    logic [1:0]    fwdA_E;
    logic [1:0]    fwdB_E;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    modport master (
        output srcA_D, srcB_D, useA_D, useB_D,
        output srcA_E, srcB_E, regScr_E, regmem_E, branch_E, taken_E, pcload_E,
        output regScr_M, regw_M, regScr_W, regw_W,
        input  stall_F, stall_D, flush_D, flush_E, fwdA_E, fwdB_E, stall_cnt, flush_cnt
    );

    modport slave (
        input  srcA_D, srcB_D, useA_D, useB_D,
        input  srcA_E, srcB_E, regScr_E, regmem_E, branch_E, taken_E, pcload_E,
        input  regScr_M, regw_M, regScr_W, regw_W,
        output stall_F, stall_D, flush_D, flush_E, fwdA_E, fwdB_E, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: hazard and forwarding controller for the 5-stage pipeline.
//   clk : rising-edge clock
//   rst : asynchronous reset, active low
//   hz  : hazard_unit_if.slave; decode/execute/memory/writeback fields in,
//         stall_F/stall_D/flush_D/flush_E, fwdA_E/fwdB_E and the saturating
//         stall/redirect counters out.
// Load-use stalls are stretched to LOAD_LAT cycles (legal 1..15) by a small
// RUN/LDSTALL FSM; all controls are combinational so they act in the same cycle.
module hazard_unit #(
    parameter int M        = 4,
    parameter int LOAD_LAT = 1,
    parameter int CW       = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_unit_if.slave hz
);
    localparam logic [0:0]    RUN     = 1'b0;
    localparam logic [0:0]    LDSTALL = 1'b1;
    localparam logic [CW-1:0] CMAX    = '1;
    localparam logic [3:0]    LD_INIT = 4'(LOAD_LAT - 1);

    logic [0:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CW-1:0] flush_cnt_q, flush_cnt_d;

    logic ldu, redir;
    logic stall, fl_d, fl_e, stall_inc, flush_inc;
    logic [1:0] fwd_a, fwd_b;

    assign ldu   = hz.regmem_E & ((hz.useA_D & (hz.srcA_D == hz.regScr_E)) |
                                  (hz.useB_D & (hz.srcB_D == hz.regScr_E)));
    assign redir = hz.pcload_E | (hz.branch_E & hz.taken_E);

    // Forwarding: the memory stage holds the younger result, so it wins over writeback.
    always_comb begin
        fwd_a = 2'b00;
        if (hz.regw_M && hz.regScr_M == hz.srcA_E)      fwd_a = 2'b10;
        else if (hz.regw_W && hz.regScr_W == hz.srcA_E) fwd_a = 2'b01;
        fwd_b = 2'b00;
        if (hz.regw_M && hz.regScr_M == hz.srcB_E)      fwd_b = 2'b10;
        else if (hz.regw_W && hz.regScr_W == hz.srcB_E) fwd_b = 2'b01;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall     = 1'b0;
        fl_d      = 1'b0;
        fl_e      = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        case (state_q)
            RUN: begin
                if (redir) begin
                    fl_d      = 1'b1;
                    fl_e      = 1'b1;
                    flush_inc = 1'b1;
                end else if (ldu) begin
                    stall     = 1'b1;
                    fl_e      = 1'b1;
                    stall_inc = 1'b1;
                    // first stall cycle is spent here; LDSTALL covers the remaining ones
                    if (LOAD_LAT > 1) begin
                        state_d = LDSTALL;
                        cnt_d   = LD_INIT;
                    end
                end
            end
            default: begin
                // ldu is not re-evaluated: the load already left execute
                if (redir) begin
                    fl_d      = 1'b1;
                    fl_e      = 1'b1;
                    flush_inc = 1'b1;
                    cnt_d     = 4'd0;
                    state_d   = RUN;
                end else begin
                    stall     = 1'b1;
                    fl_e      = 1'b1;
                    stall_inc = 1'b1;
                    cnt_d     = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = RUN;
                end
            end
        endcase
    end

    assign stall_cnt_d = (stall_inc && stall_cnt_q != CMAX) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    assign flush_cnt_d = (flush_inc && flush_cnt_q != CMAX) ? flush_cnt_q + 1'b1 : flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            cnt_q       <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // While in reset the pipeline registers are held clear and nothing is forwarded.
    assign hz.stall_F   = rst & stall;
    assign hz.stall_D   = rst & stall;
    assign hz.flush_D   = ~rst | fl_d;
    assign hz.flush_E   = ~rst | fl_e;
    assign hz.fwdA_E    = rst ? fwd_a : 2'b00;
    assign hz.fwdB_E    = rst ? fwd_b : 2'b00;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: two instances (LOAD_LAT=1/CW=16 and LOAD_LAT=3/CW=4) driven by
// directed vectors; each vector queues its hand-computed expectation tagged with
// the cycle it applies to, and a negedge monitor pops and compares.
module tb_hazard_unit;
    typedef struct packed {
        logic [3:0] srcA_D, srcB_D;
        logic       useA_D, useB_D;
        logic [3:0] srcA_E, srcB_E, regScr_E;
        logic       regmem_E, branch_E, taken_E, pcload_E;
        logic [3:0] regScr_M;
        logic       regw_M;
        logic [3:0] regScr_W;
        logic       regw_W;
    } in_t;

    typedef struct {
        int         cyc;
        int         d;
        logic [3:0] ctl;   // {stall_F, stall_D, flush_D, flush_E}
        logic [1:0] fa, fb;
        int         sc, fc;
        string      nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;
    in_t  in1 = '0;
    in_t  in3 = '0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hazard_unit_if #(.M(4), .CW(16)) if1 ();
    hazard_unit_if #(.M(4), .CW(4))  if3 ();

    assign if1.srcA_D = in1.srcA_D;     assign if3.srcA_D = in3.srcA_D;
    assign if1.srcB_D = in1.srcB_D;     assign if3.srcB_D = in3.srcB_D;
    assign if1.useA_D = in1.useA_D;     assign if3.useA_D = in3.useA_D;
    assign if1.useB_D = in1.useB_D;     assign if3.useB_D = in3.useB_D;
    assign if1.srcA_E = in1.srcA_E;     assign if3.srcA_E = in3.srcA_E;
    assign if1.srcB_E = in1.srcB_E;     assign if3.srcB_E = in3.srcB_E;
    assign if1.regScr_E = in1.regScr_E; assign if3.regScr_E = in3.regScr_E;
    assign if1.regmem_E = in1.regmem_E; assign if3.regmem_E = in3.regmem_E;
    assign if1.branch_E = in1.branch_E; assign if3.branch_E = in3.branch_E;
    assign if1.taken_E = in1.taken_E;   assign if3.taken_E = in3.taken_E;
    assign if1.pcload_E = in1.pcload_E; assign if3.pcload_E = in3.pcload_E;
    assign if1.regScr_M = in1.regScr_M; assign if3.regScr_M = in3.regScr_M;
    assign if1.regw_M = in1.regw_M;     assign if3.regw_M = in3.regw_M;
    assign if1.regScr_W = in1.regScr_W; assign if3.regScr_W = in3.regScr_W;
    assign if1.regw_W = in1.regw_W;     assign if3.regw_W = in3.regw_W;

    hazard_unit #(.M(4), .LOAD_LAT(1), .CW(16)) u1 (.clk(clk), .rst(rst), .hz(if1.slave));
    hazard_unit #(.M(4), .LOAD_LAT(3), .CW(4))  u3 (.clk(clk), .rst(rst), .hz(if3.slave));

    // monitor
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t       e;
            logic [3:0] ctl;
            logic [1:0] fa, fb;
            int         sc, fc;
            e = q.pop_front();
            if (e.d == 1) begin
                ctl = {if1.stall_F, if1.stall_D, if1.flush_D, if1.flush_E};
                fa = if1.fwdA_E; fb = if1.fwdB_E;
                sc = int'(if1.stall_cnt); fc = int'(if1.flush_cnt);
            end else begin
                ctl = {if3.stall_F, if3.stall_D, if3.flush_D, if3.flush_E};
                fa = if3.fwdA_E; fb = if3.fwdB_E;
                sc = int'(if3.stall_cnt); fc = int'(if3.flush_cnt);
            end
            nchk++;
            if (e.cyc != cyc || ctl !== e.ctl || fa !== e.fa || fb !== e.fb ||
                sc != e.sc || fc != e.fc) begin
                nerr++;
                $display("FAIL %s (u%0d cyc %0d/%0d): got ctl=%b fwdA=%b fwdB=%b sc=%0d fc=%0d, want ctl=%b fwdA=%b fwdB=%b sc=%0d fc=%0d",
                         e.nm, e.d, cyc, e.cyc, ctl, fa, fb, sc, fc, e.ctl, e.fa, e.fb, e.sc, e.fc);
            end
        end
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input int d, input logic [3:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                      input int sc, input int fc, input string nm);
        exp_t e;
        e.cyc = cyc; e.d = d; e.ctl = ctl; e.fa = fa; e.fb = fb;
        e.sc = sc; e.fc = fc; e.nm = nm;
        q.push_back(e);
    endtask

    function automatic in_t ldtrig(input logic useA, input logic useB);
        in_t v;
        v = '0;
        v.regmem_E = 1'b1; v.regScr_E = 4'd2;
        v.srcA_D = 4'd2; v.useA_D = useA;
        v.srcB_D = 4'd2; v.useB_D = useB;
        return v;
    endfunction

    localparam logic [3:0] IDLE = 4'b0000;
    localparam logic [3:0] STL  = 4'b1101;
    localparam logic [3:0] FLS  = 4'b0011;

    initial begin
        in_t v;
        // reset held
        for (int i = 0; i < 2; i++) begin
            go();
            ex(1, FLS, 2'b00, 2'b00, 0, 0, "rst_u1");
            ex(3, FLS, 2'b00, 2'b00, 0, 0, "rst_u3");
        end
        // reset with live forwarding match still forces fwd=00
        go();
        v = '0; v.regw_M = 1'b1; v.regScr_M = 4'd3; v.srcA_E = 4'd3; in1 = v;
        ex(1, FLS, 2'b00, 2'b00, 0, 0, "rst_fwd_gated");
        go(); rst = 1'b1; in1 = '0;
        ex(1, IDLE, 2'b00, 2'b00, 0, 0, "release_u1");
        ex(3, IDLE, 2'b00, 2'b00, 0, 0, "release_u3");

        // forwarding priority
        go();
        v = '0; v.regw_M = 1'b1; v.regScr_M = 4'd3; v.regw_W = 1'b1; v.regScr_W = 4'd3;
        v.srcA_E = 4'd3; v.srcB_E = 4'd5; in1 = v;
        ex(1, IDLE, 2'b10, 2'b00, 0, 0, "fwd_M_prio");
        go(); v.regw_M = 1'b0; in1 = v;
        ex(1, IDLE, 2'b01, 2'b00, 0, 0, "fwd_W");
        go(); v.srcB_E = 4'd3; v.regw_W = 1'b0; v.regw_M = 1'b1; in1 = v;
        ex(1, IDLE, 2'b10, 2'b10, 0, 0, "fwd_B_M");
        go(); v = '0; v.regw_W = 1'b1; v.regScr_W = 4'd0; in1 = v;   // r0 is forwarded too
        ex(1, IDLE, 2'b01, 2'b01, 0, 0, "fwd_zero_reg");

        // load-use, LOAD_LAT=1
        go(); in1 = ldtrig(1'b0, 1'b1);
        ex(1, STL, 2'b00, 2'b00, 0, 0, "ldu1_B");
        go(); in1 = '0;
        ex(1, IDLE, 2'b00, 2'b00, 1, 0, "ldu1_after");
        go(); in1 = ldtrig(1'b0, 1'b0);
        ex(1, IDLE, 2'b00, 2'b00, 1, 0, "ldu1_nouse");
        go(); in1 = ldtrig(1'b1, 1'b0);
        ex(1, STL, 2'b00, 2'b00, 1, 0, "ldu1_A");
        go(); in1 = '0;
        ex(1, IDLE, 2'b00, 2'b00, 2, 0, "ldu1_A_after");

        // load-use, LOAD_LAT=3
        go(); in3 = ldtrig(1'b0, 1'b1);
        ex(3, STL, 2'b00, 2'b00, 0, 0, "ldu3_c0");
        go(); in3 = '0;
        ex(3, STL, 2'b00, 2'b00, 1, 0, "ldu3_c1");
        go();
        ex(3, STL, 2'b00, 2'b00, 2, 0, "ldu3_c2");
        go();
        ex(3, IDLE, 2'b00, 2'b00, 3, 0, "ldu3_run");

        // redirects
        go(); v = '0; v.branch_E = 1'b1; v.taken_E = 1'b1; in1 = v;
        ex(1, FLS, 2'b00, 2'b00, 2, 0, "br_taken");
        go(); in1 = '0;
        ex(1, IDLE, 2'b00, 2'b00, 2, 1, "br_after");
        go(); v.taken_E = 1'b0; in1 = v;
        ex(1, IDLE, 2'b00, 2'b00, 2, 1, "br_not_taken");
        go(); v = '0; v.pcload_E = 1'b1; in1 = v;
        ex(1, FLS, 2'b00, 2'b00, 2, 1, "pcload");
        go(); v = ldtrig(1'b1, 1'b1); v.branch_E = 1'b1; v.taken_E = 1'b1; in1 = v;
        ex(1, FLS, 2'b00, 2'b00, 2, 2, "redir_over_ldu");
        go(); in1 = '0;
        ex(1, IDLE, 2'b00, 2'b00, 2, 3, "redir_over_ldu_after");

        // redirect during LDSTALL
        go(); in3 = ldtrig(1'b1, 1'b0);
        ex(3, STL, 2'b00, 2'b00, 3, 0, "ld3_redir_c0");
        go(); in3 = '0;
        ex(3, STL, 2'b00, 2'b00, 4, 0, "ld3_redir_c1");
        go(); v = '0; v.branch_E = 1'b1; v.taken_E = 1'b1; in3 = v;
        ex(3, FLS, 2'b00, 2'b00, 5, 0, "ld3_redir_flush");
        go(); in3 = '0;
        ex(3, IDLE, 2'b00, 2'b00, 5, 1, "ld3_redir_run");

        // saturation on the CW=4 instance: every cycle stalls
        go(); in3 = ldtrig(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            ex(3, STL, 2'b00, 2'b00, (5 + i > 15) ? 15 : 5 + i, 1, "sat_stall");
            go();
        end
        // 20th stall left the FSM in LDSTALL with one cycle to go
        in3 = '0;
        ex(3, STL, 2'b00, 2'b00, 15, 1, "sat_tail");
        go();
        ex(3, IDLE, 2'b00, 2'b00, 15, 1, "sat_hold");

        // reset asserted mid-LDSTALL
        go(); in3 = ldtrig(1'b0, 1'b1);
        ex(3, STL, 2'b00, 2'b00, 15, 1, "mid_rst_enter");
        go(); in3 = '0; rst = 1'b0;
        #1;
        ex(3, FLS, 2'b00, 2'b00, 0, 0, "mid_rst_held");
        go(); rst = 1'b1;
        ex(3, IDLE, 2'b00, 2'b00, 0, 0, "mid_rst_run");

        go(); go();
        nchk++;
        if (q.size() != 0) begin
            nerr++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
